// File: rtl/fft_bitrev_reorder_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared definitions for the FFT output reorder buffer.
//   DEF_LOG2N / DEF_DW : default frame size exponent and sample width
//                        (signed Q8.8 per component by default)
//   MAX_LOG2N          : widest frame exponent the bitrev helper supports
//   bank_state_t       : lifecycle tag of one ping-pong bank
//   bitrev()           : reverses the low 'width' bits of an index
// ---------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

    localparam int unsigned DEF_LOG2N = 4;
    localparam int unsigned DEF_DW    = 16;
    localparam int unsigned MAX_LOG2N = 16;

    // A bank walks EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
    typedef enum logic [1:0] {
        BANK_EMPTY    = 2'd0,
        BANK_FILLING  = 2'd1,
        BANK_FULL     = 2'd2,
        BANK_DRAINING = 2'd3
    } bank_state_t;

    // Full-width reversal followed by a right shift leaves the reversed
    // low 'width' bits in the LSBs, so one helper serves any frame size.
    function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] value,
                                                     input int unsigned width);
        logic [MAX_LOG2N-1:0] rev;
        rev = {<<{value}};
        return rev >> (MAX_LOG2N - width);
    endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// ---------------------------------------------------------------------------
// fft_pingpong_ram
// Two banks of 2**LOG2N words each, stored as one array addressed by
// {bank, index}. One synchronous write port, one combinational read port.
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : {bank, index} write address
//   wr_data_i  : word to store
//   rd_addr_i  : {bank, index} read address
//   rd_data_o  : word at rd_addr_i, same cycle
// Contents are never cleared; the control logic only ever reads locations
// written in the current frame.
// ---------------------------------------------------------------------------
module fft_pingpong_ram #(
    parameter int unsigned LOG2N = 4,
    parameter int unsigned WW    = 32
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [LOG2N:0]   wr_addr_i,
    input  logic [WW-1:0]    wr_data_i,
    input  logic [LOG2N:0]   rd_addr_i,
    output logic [WW-1:0]    rd_data_o
);

    logic [WW-1:0] mem_q [2**(LOG2N+1)];

    // Plain storage write; no reset so the array maps onto RAM primitives.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Accepts complex FFT results in bit-reversed order and re-emits them in
// natural order through a ping-pong buffer, so one frame fills while the
// previous one drains.
//   clk_i       : clock, rising edge
//   rst_i       : synchronous active-high reset
//   in_valid_i  : input sample valid
//   in_ready_o  : write bank can take a sample
//   in_re_i     : real part, bit-reversed arrival order
//   in_im_i     : imaginary part
//   out_valid_o : output sample valid
//   out_ready_i : sink accepts output
//   out_re_o    : real part, natural order
//   out_im_o    : imaginary part
//   out_idx_o   : natural-order bin index of the presented sample
//   out_last_o  : high with bin N-1
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
    import fft_bitrev_reorder_pkg::*;
#(
    parameter int unsigned LOG2N = DEF_LOG2N,
    parameter int unsigned DW    = DEF_DW
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DW-1:0]    in_re_i,
    input  logic [DW-1:0]    in_im_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DW-1:0]    out_re_o,
    output logic [DW-1:0]    out_im_o,
    output logic [LOG2N-1:0] out_idx_o,
    output logic             out_last_o
);

    localparam logic [LOG2N-1:0] LAST_IDX = '1;

    bank_state_t       tag_q [2];
    bank_state_t       tag_d [2];
    logic              wsel_q, wsel_d;
    logic              rsel_q, rsel_d;
    logic [LOG2N-1:0]  wcnt_q, wcnt_d;
    logic [LOG2N-1:0]  rcnt_q, rcnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    logic [DW-1:0]     out_re_q, out_re_d;
    logic [DW-1:0]     out_im_q, out_im_d;

    logic              in_fire;
    logic              out_fire;
    logic              ld_en;
    logic              ld_bank;
    logic [LOG2N-1:0]  ld_idx;
    logic [LOG2N-1:0]  wr_rev;
    logic [2*DW-1:0]   rd_data;

    assign in_ready_o = (tag_q[wsel_q] == BANK_EMPTY) || (tag_q[wsel_q] == BANK_FILLING);
    assign in_fire    = in_valid_i && in_ready_o;
    assign out_fire   = out_valid_q && out_ready_i;
    assign wr_rev     = LOG2N'(bitrev(MAX_LOG2N'(wcnt_q), LOG2N));

    fft_pingpong_ram #(
        .LOG2N (LOG2N),
        .WW    (2 * DW)
    ) u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (in_fire),
        .wr_addr_i ({wsel_q, wr_rev}),
        .wr_data_i ({in_re_i, in_im_i}),
        .rd_addr_i ({ld_bank, ld_idx}),
        .rd_data_o (rd_data)
    );

    // Next-state for both sides of the buffer. The write side is resolved
    // first so the read side sees a bank that completes this very cycle as
    // FULL; that is what lets bin 0 appear one cycle after the last input
    // and keeps back-to-back frames free of bubbles. Bin 0 lives at address
    // 0, written at k=0, so it is already in the array when the frame's last
    // sample lands elsewhere.
    always_comb begin
        tag_d[0]    = tag_q[0];
        tag_d[1]    = tag_q[1];
        wsel_d      = wsel_q;
        rsel_d      = rsel_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        ld_en       = 1'b0;
        ld_bank     = rsel_q;
        ld_idx      = rcnt_q;

        if (in_fire) begin
            if (wcnt_q == LAST_IDX) begin
                tag_d[wsel_q] = BANK_FULL;
                wcnt_d        = '0;
                wsel_d        = ~wsel_q;
            end else begin
                tag_d[wsel_q] = BANK_FILLING;
                wcnt_d        = wcnt_q + 1'b1;
            end
        end

        if (out_fire) begin
            if (rcnt_q == LAST_IDX) begin
                tag_d[rsel_q] = BANK_EMPTY;
                rsel_d        = ~rsel_q;
                rcnt_d        = '0;
                if (tag_d[~rsel_q] == BANK_FULL) begin
                    ld_en          = 1'b1;
                    ld_bank        = ~rsel_q;
                    ld_idx         = '0;
                    tag_d[~rsel_q] = BANK_DRAINING;
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end else begin
                rcnt_d = rcnt_q + 1'b1;
                ld_en  = 1'b1;
                ld_idx = rcnt_q + 1'b1;
            end
        end else if (!out_valid_q && (tag_d[rsel_q] == BANK_FULL)) begin
            ld_en         = 1'b1;
            ld_idx        = '0;
            rcnt_d        = '0;
            tag_d[rsel_q] = BANK_DRAINING;
        end

        if (ld_en) begin
            out_valid_d = 1'b1;
            out_re_d    = rd_data[2*DW-1:DW];
            out_im_d    = rd_data[DW-1:0];
            out_last_d  = (ld_idx == LAST_IDX);
        end
    end

    // Single state register for bank tags, selectors, counters and the
    // output register. Reset drops any partial or draining frame; RAM
    // contents are left as they are.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_q[0]    <= BANK_EMPTY;
            tag_q[1]    <= BANK_EMPTY;
            wsel_q      <= 1'b0;
            rsel_q      <= 1'b0;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            tag_q[0]    <= tag_d[0];
            tag_q[1]    <= tag_d[1];
            wsel_q      <= wsel_d;
            rsel_q      <= rsel_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_re_o    = out_re_q;
    assign out_im_o    = out_im_q;
    assign out_idx_o   = rcnt_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Self-checking bench for fft_bitrev_reorder. A frame-level reference model
// collects accepted inputs; each completed frame is turned into the expected
// natural-order output stream (bin i = sample bitrev(i)). The model also
// tracks how many complete frames are buffered, which fixes in_ready and
// out_valid.
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;

    localparam int LOG2N = 4;
    localparam int N     = 16;
    localparam int DW    = 16;

    typedef logic [36:0] obs_t;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [DW-1:0]   in_re_i;
    logic [DW-1:0]   in_im_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [DW-1:0]   out_re_o;
    logic [DW-1:0]   out_im_o;
    logic [LOG2N-1:0] out_idx_o;
    logic            out_last_o;

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] accumQ[$];
    obs_t        expQ[$];
    obs_t        obsQ[$];
    int          held       = 0;
    int          outCount   = 0;
    int          inAccepted = 0;

    fft_bitrev_reorder #(.LOG2N(LOG2N), .DW(DW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_re_i     (in_re_i),
        .in_im_i     (in_im_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_re_o    (out_re_o),
        .out_im_o    (out_im_o),
        .out_idx_o   (out_idx_o),
        .out_last_o  (out_last_o)
    );

    always #5 clk_i = ~clk_i;

    // Watchdog so the run can never hang.
    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int bitrev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < LOG2N; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    // Advance one clock: record handshakes seen just before the edge and
    // update the frame-level model. Called at the falling edge, returns at
    // the next falling edge.
    task automatic cycle();
        logic inFire, outFire;
        obs_t ob;
        inFire  = in_valid_i && in_ready_o;
        outFire = out_valid_o && out_ready_i;
        ob      = {out_last_o, out_idx_o, out_re_o, out_im_o};
        @(posedge clk_i);
        if (rst_i) begin
            accumQ.delete();
            expQ.delete();
            obsQ.delete();
            held     = 0;
            outCount = 0;
        end else begin
            if (outFire) begin
                obsQ.push_back(ob);
                outCount++;
                if (outCount % N == 0) held--;
            end
            if (inFire) begin
                inAccepted++;
                accumQ.push_back({in_re_i, in_im_i});
                if (accumQ.size() == N) begin
                    for (int idx = 0; idx < N; idx++)
                        expQ.push_back({(idx == N - 1), 4'(idx), accumQ[bitrev(idx)]});
                    accumQ.delete();
                    held++;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; in_re_i = '0; in_im_i = '0;
        cycle();
        cycle();
        rst_i = 1'b0;
        nChecks++; if (out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_valid: got %0b want 0", out_valid_o); end
        nChecks++; if (out_re_o !== 16'h0) begin nFails++; $display("[TB] FAIL reset_out_re: got %h want 0000", out_re_o); end
        nChecks++; if (out_im_o !== 16'h0) begin nFails++; $display("[TB] FAIL reset_out_im: got %h want 0000", out_im_o); end
        nChecks++; if (out_idx_o !== 4'h0) begin nFails++; $display("[TB] FAIL reset_out_idx: got %0d want 0", out_idx_o); end
        nChecks++; if (out_last_o !== 1'b0) begin nFails++; $display("[TB] FAIL reset_out_last: got %0b want 0", out_last_o); end
        nChecks++; if (in_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL reset_in_ready: got %0b want 1", in_ready_o); end
    endtask

    task automatic test_single_frame();
        int expRe[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
        obs_t ob;
        out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid_i = 1'b1;
            in_re_i    = 16'(k);
            in_im_i    = 16'(-k);
            if (k == N - 1) begin
                nChecks++; if (out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL single_early_valid: got %0b want 0", out_valid_o); end
            end
            cycle();
        end
        in_valid_i = 1'b0;
        nChecks++; if (out_valid_o !== 1'b1) begin nFails++; $display("[TB] FAIL single_latency_valid: got %0b want 1", out_valid_o); end
        nChecks++; if (out_idx_o !== 4'd0) begin nFails++; $display("[TB] FAIL single_latency_idx: got %0d want 0", out_idx_o); end
        repeat (20) cycle();
        nChecks++; if (obsQ.size() != N) begin nFails++; $display("[TB] FAIL single_count: got %0d want %0d", obsQ.size(), N); end
        for (int i = 0; i < obsQ.size() && i < N; i++) begin
            ob = obsQ[i];
            nChecks++; if (ob[31:16] !== 16'(expRe[i])) begin nFails++; $display("[TB] FAIL single_order_re[%0d]: got %0d want %0d", i, ob[31:16], expRe[i]); end
            nChecks++; if (ob[36] !== (i == N - 1)) begin nFails++; $display("[TB] FAIL single_last[%0d]: got %0b want %0b", i, ob[36], (i == N - 1)); end
            nChecks++; if (ob !== expQ[i]) begin nFails++; $display("[TB] FAIL single_word[%0d]: got %h want %h", i, ob, expQ[i]); end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        int startOut;
        startOut    = outCount;
        out_ready_i = 1'b1;
        for (int c = 0; c < 4 * N; c++) begin
            if (c < 3 * N) begin
                in_valid_i = 1'b1;
                in_re_i    = 16'($urandom);
                in_im_i    = 16'($urandom);
                nChecks++; if (in_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_in_ready[%0d]: got %0b want 1", c, in_ready_o); end
            end else begin
                in_valid_i = 1'b0;
            end
            if (outCount - startOut > 0 && outCount - startOut < 3 * N) begin
                nChecks++; if (out_valid_o !== 1'b1) begin nFails++; $display("[TB] FAIL b2b_gap[%0d]: got out_valid %0b want 1", c, out_valid_o); end
            end
            cycle();
        end
        nChecks++; if (outCount - startOut != 3 * N) begin nFails++; $display("[TB] FAIL b2b_total: got %0d outputs want %0d", outCount - startOut, 3 * N); end
        nChecks++; if (obsQ.size() != expQ.size()) begin nFails++; $display("[TB] FAIL b2b_count: got %0d want %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL b2b_word[%0d]: got %h want %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_backpressure();
        int acc0, prev, k;
        obs_t cur, hold0;
        bit have;
        acc0 = inAccepted; k = 0; have = 1'b0; hold0 = '0;
        out_ready_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_valid_i = 1'b1;
            in_re_i    = 16'(k);
            in_im_i    = 16'(k + 100);
            prev       = inAccepted;
            cycle();
            if (inAccepted != prev) k++;
            cur = {out_last_o, out_idx_o, out_re_o, out_im_o};
            if (out_valid_o) begin
                if (!have) begin
                    hold0 = cur;
                    have  = 1'b1;
                end else begin
                    nChecks++; if (cur !== hold0) begin nFails++; $display("[TB] FAIL bp_hold[%0d]: got %h want %h", c, cur, hold0); end
                end
            end
        end
        nChecks++; if (inAccepted - acc0 != 2 * N) begin nFails++; $display("[TB] FAIL bp_accepted: got %0d want %0d", inAccepted - acc0, 2 * N); end
        nChecks++; if (in_ready_o !== 1'b0) begin nFails++; $display("[TB] FAIL bp_in_ready: got %0b want 0", in_ready_o); end
        nChecks++; if (out_valid_o !== 1'b1) begin nFails++; $display("[TB] FAIL bp_out_valid: got %0b want 1", out_valid_o); end
        nChecks++; if (out_idx_o !== 4'd0) begin nFails++; $display("[TB] FAIL bp_out_idx: got %0d want 0", out_idx_o); end
        nChecks++; if (out_re_o !== 16'd0 || out_im_o !== 16'd100) begin nFails++; $display("[TB] FAIL bp_bin0: got %h/%h want 0000/0064", out_re_o, out_im_o); end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (40) cycle();
        nChecks++; if (obsQ.size() != 2 * N || expQ.size() != 2 * N) begin nFails++; $display("[TB] FAIL bp_count: got %0d want %0d", obsQ.size(), expQ.size()); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL bp_word[%0d]: got %h want %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_sign();
        out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid_i = 1'b1;
            in_re_i    = (k == 1) ? 16'b1111111101001011 : 16'($urandom);
            in_im_i    = 16'($urandom);
            cycle();
        end
        in_valid_i = 1'b0;
        repeat (20) cycle();
        nChecks++; if (obsQ.size() != N) begin nFails++; $display("[TB] FAIL sign_count: got %0d want %0d", obsQ.size(), N); end
        if (obsQ.size() > 8) begin
            nChecks++; if (obsQ[8][31:16] !== 16'hFF4B) begin nFails++; $display("[TB] FAIL sign_idx8: got %h want ff4b", obsQ[8][31:16]); end
        end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL sign_word[%0d]: got %h want %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_mid_reset();
        out_ready_i = 1'b0;
        for (int k = 0; k < N; k++) begin
            in_valid_i = 1'b1; in_re_i = 16'($urandom); in_im_i = 16'($urandom);
            cycle();
        end
        for (int j = 0; j < 7; j++) begin
            in_valid_i  = 1'b1; in_re_i = 16'($urandom); in_im_i = 16'($urandom);
            out_ready_i = (j >= 2);
            cycle();
        end
        nChecks++; if (out_valid_o !== 1'b1 || out_idx_o !== 4'd5) begin nFails++; $display("[TB] FAIL mrst_pre_idx: got valid %0b idx %0d want 1/5", out_valid_o, out_idx_o); end
        rst_i = 1'b1; in_valid_i = 1'b1; in_re_i = 16'd7;
        cycle();
        rst_i = 1'b0; in_valid_i = 1'b0;
        nChecks++; if (out_valid_o !== 1'b0) begin nFails++; $display("[TB] FAIL mrst_out_valid: got %0b want 0", out_valid_o); end
        nChecks++; if (in_ready_o !== 1'b1) begin nFails++; $display("[TB] FAIL mrst_in_ready: got %0b want 1", in_ready_o); end
        out_ready_i = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid_i = 1'b1; in_re_i = 16'($urandom); in_im_i = 16'($urandom);
            cycle();
        end
        in_valid_i = 1'b0;
        repeat (20) cycle();
        nChecks++; if (obsQ.size() != N || expQ.size() != N) begin nFails++; $display("[TB] FAIL mrst_count: got %0d want %0d", obsQ.size(), N); end
        for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
            nChecks++; if (obsQ[i] !== expQ[i]) begin nFails++; $display("[TB] FAIL mrst_word[%0d]: got %h want %h", i, obsQ[i], expQ[i]); end
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic test_random();
        int startOut, cyc;
        bit pending;
        obs_t ob, ex;
        startOut = outCount; cyc = 0; pending = 1'b0;
        while ((outCount - startOut < 1000 * N) && (cyc < 90000)) begin
            if (!pending) begin
                in_valid_i = 1'($urandom_range(0, 1));
                in_re_i    = 16'($urandom);
                in_im_i    = 16'($urandom);
            end
            out_ready_i = 1'($urandom_range(0, 1));
            pending     = in_valid_i && !in_ready_o;
            cycle();
            cyc++;
            nChecks++; if (in_ready_o !== (held < 2)) begin nFails++; $display("[TB] FAIL rand_in_ready@%0d: got %0b want %0b", cyc, in_ready_o, (held < 2)); end
            nChecks++; if (out_valid_o !== (held > 0)) begin nFails++; $display("[TB] FAIL rand_out_valid@%0d: got %0b want %0b", cyc, out_valid_o, (held > 0)); end
            while (obsQ.size() > 0) begin
                ob = obsQ.pop_front();
                nChecks++;
                if (expQ.size() == 0) begin
                    nFails++; $display("[TB] FAIL rand_extra@%0d: got %h want nothing", cyc, ob);
                end else begin
                    ex = expQ.pop_front();
                    if (ob !== ex) begin nFails++; $display("[TB] FAIL rand_word@%0d: got %h want %h", cyc, ob, ex); end
                end
            end
        end
        nChecks++; if (outCount - startOut < 1000 * N) begin nFails++; $display("[TB] FAIL rand_timeout: got %0d outputs want %0d", outCount - startOut, 1000 * N); end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        repeat (40) cycle();
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            ob = obsQ.pop_front(); ex = expQ.pop_front();
            nChecks++; if (ob !== ex) begin nFails++; $display("[TB] FAIL rand_tail_word: got %h want %h", ob, ex); end
        end
        nChecks++; if (obsQ.size() != 0 || expQ.size() != 0) begin nFails++; $display("[TB] FAIL rand_tail_count: got %0d/%0d left want 0/0", obsQ.size(), expQ.size()); end
    endtask

    // Scenario sequence: each task leaves the block idle for the next one.
    initial begin
        rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0; in_re_i = '0; in_im_i = '0;
        @(negedge clk_i);
        $display("[TB] reset");
        test_reset();
        $display("[TB] single frame");
        test_single_frame();
        $display("[TB] back to back");
        test_back_to_back();
        $display("[TB] backpressure");
        test_backpressure();
        $display("[TB] sign");
        test_sign();
        $display("[TB] mid-frame reset");
        test_mid_reset();
        $display("[TB] random");
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
